// File: rtl/screen_pkg.sv
// Shared Screen-block definitions: bitmap geometry, VRAM port widths and the fill engine state type.
package screen_pkg;

  localparam int SCREEN_WORDS_PER_ROW = 32;
  localparam int SCREEN_ROWS          = 256;
  localparam int VRAM_ADDR_W          = 13;
  localparam int VRAM_DATA_W          = 16;
  localparam int ROW_W                = 8;
  localparam int COL_W                = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } fill_state_t;

endpackage

// File: rtl/vram_fill_engine.sv
// VRAM row fill/clear engine driving the Screen CPU-side VRAM port; writes a pattern to every word of a row range.
// Define VRAM_FILL_XOR_EN to read-modify-write each word as (old ^ pattern) instead of overwriting.
module vram_fill_engine
  import screen_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ROW_W-1:0]       first_row,
  input  logic [ROW_W-1:0]       last_row,
  input  logic [VRAM_DATA_W-1:0] pattern,
  output logic                   busy,
  output logic                   done,
  output logic                   vram_load,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  output logic [VRAM_DATA_W-1:0] vram_din,
  input  logic                   vram_busy,
  input  logic [VRAM_DATA_W-1:0] vram_dout,
  output fill_state_t            dbg_state
);

  // VRAM handshake: a write is taken on any cycle with vram_load=1 and vram_busy=0, a read on any
  // cycle with vram_load=0 and vram_busy=0 (data on vram_dout the next cycle); while vram_busy=1
  // the engine holds vram_load, vram_addr and vram_din unchanged.

  fill_state_t            state_q, state_d;
  logic [VRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [VRAM_ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [VRAM_DATA_W-1:0] pat_q, pat_d;
  logic [VRAM_DATA_W-1:0] wr_data;
  logic                   wr_accept;

`ifdef VRAM_FILL_XOR_EN
  logic [VRAM_DATA_W-1:0] din_q, din_d;
  logic                   rd_fresh_q;
`else
  logic                   dout_unused;
  assign dout_unused = ^vram_dout;
`endif

  assign wr_accept = (state_q == WRITE) && !vram_busy;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    pat_d       = pat_q;
    busy        = 1'b0;
    done        = 1'b0;
    vram_load   = 1'b0;
`ifdef VRAM_FILL_XOR_EN
    din_d       = din_q;
    // Read data is only valid on the first WRITE cycle; a stalled write replays the captured word.
    wr_data     = rd_fresh_q ? (vram_dout ^ pat_q) : din_q;
`else
    wr_data     = pat_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d       = pattern;
          last_addr_d = {last_row, {COL_W{1'b1}}};
          if (first_row <= last_row) begin
            addr_d = {first_row, {COL_W{1'b0}}};
`ifdef VRAM_FILL_XOR_EN
            state_d = READ;
`else
            state_d = WRITE;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        busy = 1'b1;
`ifdef VRAM_FILL_XOR_EN
        if (!vram_busy) state_d = WRITE;
`else
        state_d = IDLE;
`endif
      end
      WRITE: begin
        busy      = 1'b1;
        vram_load = 1'b1;
`ifdef VRAM_FILL_XOR_EN
        din_d     = wr_data;
`endif
        if (wr_accept) begin
          if (addr_q == last_addr_q) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + 1'b1;
`ifdef VRAM_FILL_XOR_EN
            state_d = READ;
`endif
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      last_addr_q <= '0;
      pat_q       <= '0;
`ifdef VRAM_FILL_XOR_EN
      din_q       <= '0;
      rd_fresh_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      pat_q       <= pat_d;
`ifdef VRAM_FILL_XOR_EN
      din_q       <= din_d;
      rd_fresh_q  <= (state_q == READ) && !vram_busy;
`endif
    end
  end

  assign vram_addr = addr_q;
  assign vram_din  = wr_data;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vram_fill_engine.sv
// Scoreboard bench for vram_fill_engine: a VRAM model with random/scripted busy, expected write queue
// built from row-range arithmetic, and a negedge monitor that pops and compares every accepted write.
module tb_vram_fill_engine;
  import screen_pkg::*;

  localparam int AW = VRAM_ADDR_W;
  localparam int DW = VRAM_DATA_W;
  localparam int EW = AW + DW;
`ifdef VRAM_FILL_XOR_EN
  localparam bit XOR_MODE = 1'b1;
`else
  localparam bit XOR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start;
  logic [7:0]    first_row, last_row;
  logic [DW-1:0] pattern;
  logic          busy, done, vram_load, vram_busy;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_din, vram_dout;
  fill_state_t   dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  vram_fill_engine dut (
    .clk(clk), .reset(reset), .start(start), .first_row(first_row), .last_row(last_row),
    .pattern(pattern), .busy(busy), .done(done), .vram_load(vram_load), .vram_addr(vram_addr),
    .vram_din(vram_din), .vram_busy(vram_busy), .vram_dout(vram_dout), .dbg_state(dbg_state)
  );

  logic [DW-1:0] mem     [0:8191];
  logic [DW-1:0] ref_mem [0:8191];
  logic [EW-1:0] exp_q[$];

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;
  int cyc = 0;
  int last_wr_cyc = -1;
  bit rand_busy = 1'b0;
  bit stall_armed = 1'b0;
  int stall_left = 0;
  logic rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_din;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // VRAM model: busy generation and registered read data
  initial begin
    vram_busy = 1'b0;
    vram_dout = '0;
    forever begin
      @(posedge clk); #1;
      if (rd_pend) vram_dout = mem[rd_addr];
      if (stall_left > 0) begin
        vram_busy = 1'b1;
        stall_left--;
      end else if (stall_armed && vram_load && vram_addr == 13'h0145) begin
        stall_armed = 1'b0;
        vram_busy   = 1'b1;
        stall_left  = 2;
      end else begin
        vram_busy = rand_busy ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_stall = 1'b0;
      rd_pend    = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {vram_load, vram_addr, vram_din}, {1'b1, prev_addr, prev_din});
      if (vram_load && !vram_busy) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", vram_addr, vram_din);
        end else begin
          check("write", {vram_addr, vram_din}, exp_q.pop_front());
        end
`ifdef VRAM_FILL_XOR_EN
        if (last_wr_cyc >= 0) check("xor_gap_ge2", (cyc - last_wr_cyc) >= 2, 1);
`endif
        last_wr_cyc = cyc;
        mem[vram_addr] = vram_din;
        wr_cnt++;
      end
      rd_pend    = !vram_load && !vram_busy;
      rd_addr    = vram_addr;
      prev_stall = vram_load && vram_busy;
      prev_addr  = vram_addr;
      prev_din   = vram_din;
    end
  end

  // reference model: every word of rows first..last, in ascending address order
  task automatic push_fill(input int f, input int l, input logic [DW-1:0] p);
    logic [DW-1:0] d;
    for (int a = f * SCREEN_WORDS_PER_ROW; a <= l * SCREEN_WORDS_PER_ROW + SCREEN_WORDS_PER_ROW - 1; a++) begin
      d = XOR_MODE ? (ref_mem[a] ^ p) : p;
      ref_mem[a] = d;
      exp_q.push_back({a[AW-1:0], d});
    end
  endtask

  task automatic issue_start(input int f, input int l, input logic [DW-1:0] p);
    @(posedge clk); #1;
    start = 1'b1; first_row = f[7:0]; last_row = l[7:0]; pattern = p;
    @(posedge clk); #1;
    start = 1'b0; first_row = 8'($urandom); last_row = 8'($urandom); pattern = DW'($urandom);
  endtask

  task automatic run_fill(input int f, input int l, input logic [DW-1:0] p, input bit chk_lat, input bit poke);
    int words, lat, wr0, limit;
    words = (f <= l) ? (l - f + 1) * SCREEN_WORDS_PER_ROW : 0;
    limit = words * 10 + 20;
    wr0 = wr_cnt;
    lat = 0;
    push_fill(f, l, p);
    issue_start(f, l, p);
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (poke && i == 4) begin start = 1'b1; first_row = 8'd0; last_row = 8'd255; end
      if (poke && i == 6) start = 1'b0;
      if (done) begin lat = i; break; end
    end
    check("done_seen", lat != 0, 1);
    if (chk_lat)
      check("done_latency", lat, (words == 0) ? 1 : words * (XOR_MODE ? 2 : 1) + 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("write_count", wr_cnt - wr0, words);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int f, l, wr0;
    logic [DW-1:0] p;
    for (int a = 0; a < 8192; a++) begin
      mem[a] = DW'($urandom);
      ref_mem[a] = mem[a];
    end
    reset = 1'b1; start = 1'b0; first_row = '0; last_row = '0; pattern = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load", vram_load, 0);
    check("rst_addr", vram_addr, 0);
    check("rst_din", vram_din, 0);
    check("rst_state", dbg_state, IDLE);
    @(posedge clk); #1; reset = 1'b0;

    // single row, full-speed
    run_fill(0, 0, 16'hAAAA, 1, 0);
    // top row: ends exactly at 8191
    run_fill(255, 255, 16'h5A5A, 1, 0);
    // empty range: done only, no VRAM access
    run_fill(10, 9, 16'h1234, 1, 0);
    // scripted 3-cycle stall at 0x0145
    stall_armed = 1'b1;
    run_fill(10, 10, 16'hC3C3, 0, 0);
    check("stall_consumed", stall_armed, 0);
    // start while busy is ignored
    run_fill(20, 21, 16'h0F0F, 1, 1);

    // reset during the 5th write aborts the fill
    wr0 = wr_cnt;
    push_fill(3, 4, 16'h7E7E);
    issue_start(3, 4, 16'h7E7E);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (wr_cnt - wr0 >= 5) break;
    end
    check("abort_reached_5", wr_cnt - wr0, 5);
    reset = 1'b1;
    @(negedge clk); #1;
    check("abort_load", vram_load, 0);
    check("abort_busy", busy, 0);
    exp_q.delete();
    ref_mem = mem;
    @(posedge clk); #1; reset = 1'b0;
    run_fill(3, 4, 16'h7E7E, 1, 0);

    // word 40 is row 1, word 8
    mem[40] = 16'h0F0F;
    ref_mem[40] = 16'h0F0F;
    run_fill(1, 1, 16'h00FF, 1, 0);
    check("mem40", mem[40], XOR_MODE ? 16'h0FF0 : 16'h00FF);

    // randomized fills under random backpressure
    rand_busy = 1'b1;
    for (int n = 0; n < 6; n++) begin
      f = $urandom_range(0, 255);
      l = f + $urandom_range(0, 3);
      if (l > 255) l = 255;
      if ($urandom_range(0, 4) == 0 && f > 0) l = f - 1;
      p = DW'($urandom);
      run_fill(f, l, p, 0, 0);
    end
    rand_busy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
